// File: rtl/mult_product_accumulator.sv
// Saturating burst accumulator behind the 4x4 array multiplier.
// Sums up to BURST_LEN products per result, then holds the result until the consumer takes it.
module mult_product_accumulator #(
  parameter int unsigned PROD_W    = 8,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [PROD_W-1:0] i_prod_in,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  input  logic              i_flush,
  output logic [ACC_W-1:0]  o_acc_sum,
  output logic [CNT_W-1:0]  o_acc_count,
  output logic              o_acc_sat,
  output logic              o_acc_valid,
  input  logic              i_acc_ready
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc_sum;
  logic [CNT_W-1:0]   r_acc_count;
  logic               r_acc_sat;

  logic               w_accept;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_overflow;
  logic [ACC_W-1:0]   w_sum_sat;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_burst_done;
  logic               w_flush_close;

  always_comb begin
    w_accept      = i_prod_valid && (r_state == StAccum);
    w_sum_ext     = {1'b0, r_acc_sum} + (ACC_W + 1)'(i_prod_in);
    w_overflow    = w_sum_ext[ACC_W];
    w_sum_sat     = w_overflow ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
    w_count_inc   = r_acc_count + CNT_W'(1);
    w_burst_done  = w_accept && (w_count_inc == CNT_W'(BURST_LEN));
    // An empty burst is never closed by flush; a same-cycle accept makes it non-empty.
    w_flush_close = i_flush && ((r_acc_count != '0) || w_accept);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StAccum;
      r_acc_sum   <= '0;
      r_acc_count <= '0;
      r_acc_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_accept) begin
            r_acc_sum   <= w_sum_sat;
            r_acc_sat   <= r_acc_sat | w_overflow;
            r_acc_count <= w_count_inc;
          end
          if (w_burst_done || w_flush_close) begin
            r_state <= StHold;
          end
        end
        StHold: begin
          if (i_acc_ready) begin
            r_state     <= StAccum;
            r_acc_sum   <= '0;
            r_acc_count <= '0;
            r_acc_sat   <= 1'b0;
          end
        end
        default: r_state <= StAccum;
      endcase
    end
  end

  assign o_prod_ready = (r_state == StAccum);
  assign o_acc_valid  = (r_state == StHold);
  assign o_acc_sum    = r_acc_sum;
  assign o_acc_count  = r_acc_count;
  assign o_acc_sat    = r_acc_sat;

endmodule
